// File: rtl/score_hex_driver.sv
// Multi-player score display driver: round-robin binary-to-BCD conversion (double dabble)
// feeding registered active-low 7-segment outputs with leading-zero blanking and blink.
module score_hex_driver #(
    parameter int SCORE_W   = 10,
    parameter int DIGITS    = 3,
    parameter int PLAYERS   = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PLAYERS*SCORE_W-1:0]    scores_in,
    input  logic                          blank_lz,
    input  logic [PLAYERS-1:0]            blink_mask,
    output logic [7*DIGITS*PLAYERS-1:0]   hex_out,
    output logic [PLAYERS-1:0]            overflow,
    output logic                          busy,
    output logic                          upd_done
);

    localparam int PTR_W   = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int BCD_W   = 4 * DIGITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [1:0]                state;
    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_next;
    logic [PLAYERS-1:0]        valid;
    logic [PLAYERS-1:0]        converted;
    logic [SCORE_W-1:0]        score_arr   [PLAYERS];
    logic [SCORE_W-1:0]        last_sample [PLAYERS];
    logic [BCD_W-1:0]          digit_reg   [PLAYERS];
    logic [SCORE_W-1:0]        shift_reg;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [BCD_W-1:0]          bcd_shift;
    logic [CNT_W-1:0]          bit_cnt;
    logic [BLINK_W-1:0]        blink_cnt;
    logic                      phase;
    logic [7*DIGITS*PLAYERS-1:0] hex_next;
    logic                      lead;
    logic                      blank_d;
    logic [3:0]                dig;

    always_comb begin
        for (int p = 0; p < PLAYERS; p++) score_arr[p] = scores_in[p*SCORE_W +: SCORE_W];
    end

    assign ptr_next = (ptr == PTR_W'(PLAYERS - 1)) ? '0 : ptr + 1'b1;
    assign busy     = (state != IDLE);
    assign upd_done = (state == STORE);

    // One double-dabble step; carries out of the top digit are dropped since such values saturate.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], shift_reg[SCORE_W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            valid     <= '0;
            converted <= '0;
            overflow  <= '0;
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                last_sample[p] <= '0;
                digit_reg[p]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!valid[ptr] || (score_arr[ptr] != last_sample[ptr])) state <= LOAD;
                    else ptr <= ptr_next;
                end
                LOAD: begin
                    shift_reg        <= score_arr[ptr];
                    last_sample[ptr] <= score_arr[ptr];
                    valid[ptr]       <= 1'b1;
                    bcd              <= '0;
                    bit_cnt          <= '0;
                    state            <= SHIFT;
                end
                SHIFT: begin
                    bcd       <= bcd_shift;
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(SCORE_W - 1)) state <= STORE;
                end
                STORE: begin
                    if (64'(last_sample[ptr]) >= LIMIT) begin
                        digit_reg[ptr] <= {DIGITS{4'd9}};
                        overflow[ptr]  <= 1'b1;
                    end else begin
                        digit_reg[ptr] <= bcd;
                        overflow[ptr]  <= 1'b0;
                    end
                    converted[ptr] <= 1'b1;
                    ptr            <= ptr_next;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Scan each player's digits from the top so leading zeros blank until the first nonzero digit.
    always_comb begin
        hex_next = '1;
        lead     = 1'b1;
        blank_d  = 1'b1;
        dig      = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            lead = 1'b1;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                dig = digit_reg[p][4*d +: 4];
                if ((dig != 4'd0) || (d == 0)) lead = 1'b0;
                blank_d = !converted[p] || (blink_mask[p] && phase) || (blank_lz && lead);
                hex_next[(p*DIGITS + d)*7 +: 7] = blank_d ? 7'b1111111 : seg7(dig);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hex_out <= '1;
        else       hex_out <= hex_next;
    end

endmodule
